// File: rtl/gcd_pkg.sv
// Shared types and helpers for the GCD calculator: operand width, core FSM states,
// seven-segment encoding and the decimal split used by the display.
package gcd_pkg;

  localparam int W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low {dp,g,f,e,d,c,b,a}; dp stays off.
  function automatic logic [7:0] seg7(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Values never exceed 31, so three compare/subtract stages cover every tens digit.
  function automatic logic [7:0] bcd_split(input logic [W-1:0] v);
    logic [W-1:0] rem;
    logic [3:0]   tens;
    if (v >= W'(30)) begin
      tens = 4'd3;
      rem  = v - W'(30);
    end else if (v >= W'(20)) begin
      tens = 4'd2;
      rem  = v - W'(20);
    end else if (v >= W'(10)) begin
      tens = 4'd1;
      rem  = v - W'(10);
    end else begin
      tens = 4'd0;
      rem  = v;
    end
    return {tens, rem[3:0]};
  endfunction

endpackage

// File: rtl/gcd_core.sv
// Subtractive GCD engine: latches operands on start, performs one subtraction per
// cycle, and holds the result with res_rdy until the next start.
module gcd_core
  import gcd_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] result,
  output logic         res_rdy,
  output logic [W-1:0] op_a_o,
  output logic [W-1:0] op_b_o,
  output state_e       state_o
);

  state_e       state_q, state_d;
  logic [W-1:0] x_q, x_d, y_q, y_d;
  logic [W-1:0] res_q, res_d;
  logic [W-1:0] opa_q, opa_d, opb_q, opb_d;
  logic         rdy_q, rdy_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      res_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      res_q   <= res_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      rdy_q   <= rdy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    res_d   = res_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    rdy_d   = rdy_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          x_d     = a;
          y_d     = b;
          opa_d   = a;
          opb_d   = b;
          rdy_d   = 1'b0;
          state_d = CALC;
        end
      end
      CALC: begin
        // A zero operand ends the loop too, so gcd(n,0)=n and gcd(0,0)=0 fall out of x|y.
        if ((x_q == y_q) || (x_q == '0) || (y_q == '0)) begin
          res_d   = x_q | y_q;
          rdy_d   = 1'b1;
          state_d = DONE;
        end else if (x_q > y_q) begin
          x_d = x_q - y_q;
        end else begin
          y_d = y_q - x_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign result  = res_q;
  assign res_rdy = rdy_q;
  assign op_a_o  = opa_q;
  assign op_b_o  = opb_q;
  assign state_o = state_q;

endmodule

// File: rtl/gcd_top.sv
// Board-level GCD calculator: START key synchronizer/debouncer, gcd_core, and a
// six-digit multiplexed seven-segment display of op_a, op_b and the result.
module gcd_top
  import gcd_pkg::*;
#(
  parameter int DEB_CYCLES = 4,
  parameter int SCAN_DIV   = 1000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   col,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         row,
  output logic [5:0]   seg_sel,
  output logic [7:0]   seg_led,
  output logic         res_rdy
);

  localparam int DCW = $clog2(DEB_CYCLES) + 1;
  localparam int SDW = $clog2(SCAN_DIV) + 1;

  logic [1:0]   sync_q;
  logic         key_sync;
  logic         deb_q, deb_d, deb_prev_q;
  logic [DCW-1:0] deb_cnt_q, deb_cnt_d;
  logic         start;
  logic [W-1:0] result, op_a, op_b;
  state_e       core_state;
  logic         unused_cols;

  assign row         = 1'b0;
  assign unused_cols = ^col[3:1];
  assign key_sync    = sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= 2'b11;
      deb_q      <= 1'b1;
      deb_prev_q <= 1'b1;
      deb_cnt_q  <= '0;
    end else begin
      sync_q     <= {sync_q[0], col[0]};
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      deb_cnt_q  <= deb_cnt_d;
    end
  end

  // The counter only runs while the synchronized level disagrees with the accepted one.
  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = '0;
    if (key_sync != deb_q) begin
      if (deb_cnt_q == DCW'(DEB_CYCLES - 1)) begin
        deb_d = key_sync;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
  end

  assign start = deb_prev_q & ~deb_q;

  gcd_core u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .result  (result),
    .res_rdy (res_rdy),
    .op_a_o  (op_a),
    .op_b_o  (op_b),
    .state_o (core_state)
  );

  logic [SDW-1:0] div_q;
  logic [2:0]     idx_q, idx_nxt;
  logic [5:0]     sel_q;
  logic [7:0]     led_q, led_nxt;
  logic           slot_end;
  logic [7:0]     bcd_a, bcd_b, bcd_r;

  assign bcd_a    = bcd_split(op_a);
  assign bcd_b    = bcd_split(op_b);
  assign bcd_r    = bcd_split(result);
  assign slot_end = (div_q == SDW'(SCAN_DIV - 1));
  assign idx_nxt  = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;

  always_comb begin
    led_nxt = SEG_BLANK;
    case (idx_nxt)
      3'd0:    led_nxt = res_rdy ? seg7(bcd_r[3:0]) : SEG_BLANK;
      3'd1:    led_nxt = res_rdy ? seg7(bcd_r[7:4]) : SEG_BLANK;
      3'd2:    led_nxt = seg7(bcd_b[3:0]);
      3'd3:    led_nxt = seg7(bcd_b[7:4]);
      3'd4:    led_nxt = seg7(bcd_a[3:0]);
      3'd5:    led_nxt = seg7(bcd_a[7:4]);
      default: led_nxt = SEG_BLANK;
    endcase
  end

  // Outputs are loaded with the next digit's pattern so they only move at slot boundaries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      idx_q <= 3'd0;
      sel_q <= 6'b111110;
      led_q <= SEG_BLANK;
    end else if (slot_end) begin
      div_q <= '0;
      idx_q <= idx_nxt;
      sel_q <= ~(6'b000001 << idx_nxt);
      led_q <= led_nxt;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  assign seg_sel = sel_q;
  assign seg_led = led_q;

endmodule

// File: tb/tb_gcd_top.sv
// Directed bench for gcd_top: reset state, key latency, GCD results and latency,
// operand sampling, glitch rejection and display scan order.
module tb_gcd_top;

  localparam int DEB  = 4;
  localparam int SCAN = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] col;
  logic [4:0] a, b;
  logic       row;
  logic [5:0] seg_sel;
  logic [7:0] seg_led;
  logic       res_rdy;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];
  logic [7:0] seg_tbl [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  gcd_top #(.DEB_CYCLES(DEB), .SCAN_DIV(SCAN)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .col     (col),
    .a       (a),
    .b       (b),
    .row     (row),
    .seg_sel (seg_sel),
    .seg_led (seg_led),
    .res_rdy (res_rdy)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, expv);
    end
  endtask

  // Press START with the given operands; res_rdy must rise DEB+4+k edges after the press.
  task automatic press(input logic [4:0] av, input logic [4:0] bv, input int k,
                       input int res, input bit disturb);
    int  n;
    bit  saw_low;
    bit  seen;
    a = av;
    b = bv;
    col = 4'b1110;
    n = 0;
    saw_low = 1'b0;
    seen = 1'b0;
    exp_q.push_back(res);
    while (n < 80 && !seen) begin
      step();
      n++;
      if (disturb && n == DEB + 3) begin
        a = 5'($urandom_range(0, 31));
        b = 5'($urandom_range(0, 31));
      end
      if (!res_rdy) saw_low = 1'b1;
      seen = saw_low && res_rdy;
    end
    chk("gcd_latency", n, DEB + 4 + k);
  endtask

  task automatic release_key();
    col = 4'b1111;
    repeat (DEB + 4) step();
  endtask

  function automatic logic [7:0] exp_digit(input int idx, input int opa, input int opb, input int res);
    case (idx)
      0: return seg_tbl[res % 10];
      1: return seg_tbl[res / 10];
      2: return seg_tbl[opb % 10];
      3: return seg_tbl[opb / 10];
      4: return seg_tbl[opa % 10];
      default: return seg_tbl[opa / 10];
    endcase
  endfunction

  task automatic check_display(input int opa, input int opb);
    int res;
    int w;
    logic [5:0] want_sel;
    res = int'(exp_q.pop_front());
    repeat (6 * SCAN + 2) step();
    for (int idx = 0; idx < 6; idx++) begin
      want_sel = ~(6'b000001 << idx);
      w = 0;
      while (seg_sel !== want_sel && w < 30) begin
        step();
        w++;
      end
      chk("digit_sel_wait", seg_sel, want_sel);
      chk($sformatf("digit%0d_seg", idx), seg_led, exp_digit(idx, opa, opb, res));
    end
  endtask

  initial begin
    logic [5:0] prev, cur;
    int run;
    bit changed_once;

    rst_n = 1'b0;
    col   = 4'b0000;
    a     = 5'd31;
    b     = 5'd31;
    repeat (3) step();
    chk("reset_row", row, 0);
    chk("reset_res_rdy", res_rdy, 0);
    chk("reset_seg_sel", seg_sel, 6'b111110);
    chk("reset_seg_led", seg_led, 8'hFF);
    chk("reset_state", dut.core_state, 0);

    // Key held low across reset release: exactly one computation.
    rst_n = 1'b1;
    press(5'd31, 5'd31, 0, 31, 1'b0);
    check_display(31, 31);
    repeat (20) step();
    chk("hold_res_rdy", res_rdy, 1);
    chk("hold_state_done", dut.core_state, 2);
    release_key();

    press(5'd31, 5'd1, 30, 1, 1'b0);
    check_display(31, 1);
    release_key();

    // Operands change mid-computation; result and display must follow the latched values.
    press(5'd24, 5'd18, 3, 6, 1'b1);
    check_display(24, 18);
    release_key();

    press(5'd0, 5'd13, 0, 13, 1'b0);
    check_display(0, 13);
    release_key();

    press(5'd0, 5'd0, 0, 0, 1'b0);
    check_display(0, 0);
    release_key();

    // Glitch shorter than the debounce window.
    col = 4'b1110;
    repeat (DEB - 1) step();
    col = 4'b1111;
    repeat (20) step();
    chk("glitch_res_rdy", res_rdy, 1);
    chk("glitch_state", dut.core_state, 2);

    // Scan walk: one low bit, rotate left each slot, SCAN cycles per slot.
    prev = seg_sel;
    run = 1;
    changed_once = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      cur = seg_sel;
      chk("scan_onehot", $countones(~cur), 1);
      if (cur !== prev) begin
        chk("scan_order", cur, {prev[4:0], prev[5]});
        if (changed_once) chk("scan_slot_len", run, SCAN);
        changed_once = 1'b1;
        run = 1;
      end else begin
        run++;
      end
      prev = cur;
    end
    chk("scan_moved", changed_once, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gcd_top.md
# gcd_top

Top-level GCD calculator for the FPGA board. A single-row keypad key starts the computation. The block computes the greatest common divisor of two 5-bit switch operands by iterative subtraction. Operands and result are shown in decimal on a 6-digit multiplexed seven-segment display, and completion is flagged on `res_rdy`.

## Interface
- `DEB_CYCLES`, default 4: cycles a key level must stay stable before it is accepted.
- `SCAN_DIV`, default 1000: clock cycles per display digit slot.
- `clk`, input, 1: system clock, rising edge.
- `rst_n`, input, 1: asynchronous active-low reset. One clock domain; reset is asynchronous and active-low.
- `col`, input, 4: keypad column lines, active-low. `col[0]` is the START key; `col[3:1]` are ignored.
- `a`, input, 5: operand A, unsigned 0..31.
- `b`, input, 5: operand B, unsigned 0..31.
- `row`, output, 1: keypad row drive, held constant 0.
- `seg_sel`, output, 6: digit select, active-low one-hot. Bit 5 is the leftmost digit.
- `seg_led`, output, 8: segments `{dp,g,f,e,d,c,b,a}`, active-low. `dp` is always 1.
- `res_rdy`, output, 1: result valid.

## Operation
- **Key path**
  - `col[0]` passes through a 2-flop synchronizer, then a debouncer.
  - The debounced level resets to released (1). It changes only after the synchronized level differs from it for `DEB_CYCLES` consecutive cycles.
  - The released→pressed transition produces a one-cycle `start` pulse. A held key produces exactly one pulse.
- **GCD core FSM**, states IDLE, CALC, DONE:
  - IDLE/DONE + `start`: latch `a` → `x` and `op_a`, `b` → `y` and `op_b`. Clear `res_rdy`. Go to CALC.
  - CALC, one step per cycle:
    - If `x==y`, or `x==0`, or `y==0`: result = `x|y`, go to DONE.
    - Else if `x>y`: `x <= x-y`.
    - Else: `y <= y-x`.
  - DONE: `res_rdy=1` and result held until the next `start`.
  - `start` during CALC is ignored.
- **Arithmetic**
  - All values are 5-bit unsigned. Subtraction never underflows.
  - gcd(0,0)=0, gcd(n,0)=n, gcd(0,n)=n.
- **Display**
  - Digits 5–4: `op_a`, decimal tens/units.
  - Digits 3–2: `op_b`, decimal tens/units.
  - Digits 1–0: result when `res_rdy=1`; blank (`seg_led=8'hFF`) otherwise.
  - Leading zeros are shown (e.g. "07").
  - Scan order is digit 0→5, wrapping. Each digit is active for `SCAN_DIV` cycles.
  - Encoding is active-low: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.

## Timing
- **Reset values**
  - `row=0`, `res_rdy=0`, FSM in IDLE.
  - `op_a`, `op_b`, `x`, `y`, result all 0.
  - Scan index 0: `seg_sel=6'b111110`, `seg_led=8'hFF` (result blank).
- **Key latency:** `start` fires 2 (sync) + `DEB_CYCLES` cycles after `col[0]` goes low and stays low.
- **GCD latency**
  - With `start` in cycle T and k subtraction steps needed, `res_rdy` rises at T+k+2.
  - Worst case is (31,1) or (1,31): k=30.
  - (31,31) has k=0, so `res_rdy` rises at T+2.
- **Operand sampling:** `a`/`b` are sampled only in the `start` cycle. Later changes do not affect the running computation or the display.
- **Reset mid-operation:** asynchronous reset returns everything to reset values immediately.
- **Display outputs:** registered, change only at slot boundaries.

## Structure
- Shared package `gcd_pkg`:
  - operand width constant (5).
  - FSM state enum {IDLE, CALC, DONE}.
  - seven-segment decode function/table.
  - blank code 8'hFF.
- Sub-module `gcd_core`: FSM and datapath, with ports `clk`, `rst_n`, `start`, `a`, `b`, `result`, `res_rdy`.
- Key synchronizer/debouncer and display scanner stay in `gcd_top`.
- Binary-to-decimal split is done by comparison/subtraction (value < 32). It is combinational.

## Test plan
- **Reset:** hold `rst_n=0` with `col=4'b0000` → `row=0`, `res_rdy=0`, all digits 0 except the result digits, which are blank. No `start` while in reset.
- **Basic start:** `a=31`, `b=31`; release reset with `col[0]` held low → one `start` after 2+`DEB_CYCLES` cycles, `res_rdy` 2 cycles later, display "31 31 31". Continued hold gives no second computation.
- **Worst case:** `a=31`, `b=1` → `res_rdy` 32 cycles after `start`, result 1.
- **Typical:** `a=24`, `b=18` → result 6. Then `a=0`, `b=13` → result 13. Then `a=0`, `b=0` → result 00.
- **Sampling and bounce:** change `a`/`b` during CALC → result and operand digits unaffected. Apply a glitch on `col[0]` shorter than `DEB_CYCLES` → no `start`.
- **Scan:** `SCAN_DIV=4` → `seg_sel` walks 111110→011111 every 4 cycles, wraps, and always has exactly one low bit.
